seg7_scan_display: RTL and testbench



---
 rtl/seg7_scan_display_pkg.sv | 33 +++
 rtl/seg7_scan_display_hex_to_seg7.sv | 12 +
 rtl/seg7_scan_display.sv | 90 +++++++++
 tb/tb_seg7_scan_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the 7-segment scan display: segment table, off patterns
// and the per-slot scan state encoding.
package seg7_scan_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Active-low seg[6:0] patterns, entry n at HEX_SEG_TABLE[n].
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder; also used by other
// debug displays.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_display.sv
// Captures the core's outM / ALU flags and scans them as four hex digits with
// flag decimal points on a common-anode display, blanking at each slot start.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value_in,
    input  logic        value_we,
    input  logic        zr_in,
    input  logic        ng_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] shown_value
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [15:0]  display_q;
    logic         zr_q;
    logic         ng_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]   idx_q;
    scan_state_e  state_q;
    logic [3:0]   nibble;
    logic [6:0]   digit_seg;

    assign nibble = display_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (digit_seg)
    );

    assign shown_value = display_q;

    // Outputs are computed from the pre-edge counter/state, so an, seg and dp
    // all switch together on the same edge one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            display_q <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            state_q   <= BLANK;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
            an        <= AN_OFF;
        end else begin
            if (value_we) begin
                display_q <= value_in;
                zr_q      <= zr_in;
                ng_q      <= ng_in;
            end

            if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                idx_q   <= idx_q + 2'd1;
                state_q <= BLANK;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                if (state_q == BLANK && cnt_q == BLANK_LAST) begin
                    state_q <= SHOW;
                end
            end

            if (state_q == SHOW) begin
                an  <= ~(4'b0001 << idx_q);
                seg <= digit_seg;
                case (idx_q)
                    2'd0:    dp <= ~zr_q;
                    2'd1:    dp <= ~ng_q;
                    default: dp <= 1'b1;
                endcase
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with short scan slots: vector table, directed
// corner sequences and random captures against a slot-arithmetic model.
module tb_seg7_scan_display;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clk;
    logic        reset_n;
    logic [15:0] value_in;
    logic        value_we;
    logic        zr_in;
    logic        ng_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] shown_value;

    seg7_scan_display #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value_in    (value_in),
        .value_we    (value_we),
        .zr_in       (zr_in),
        .ng_in       (ng_in),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .shown_value (shown_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tbl [16];

    // Reference model state: edges since reset release and the captured data.
    int          cyc_m;
    logic [15:0] disp_m;
    logic        zr_m;
    logic        ng_m;
    int          blank_cnt;

    typedef struct {
        logic [15:0]     value;
        logic            zr;
        logic            ng;
        logic [3:0][6:0] exp_seg;
        logic [3:0]      exp_dp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs seen after edge k reflect the slot position before that edge.
    task automatic exp_out(input int k, input logic [15:0] d, input logic z, input logic n,
                           output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
        int c, digit;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (k >= 1) begin
            c     = (k - 1) % SCAN_DIV;
            digit = ((k - 1) / SCAN_DIV) % 4;
            if (c >= BLANK_CYCLES) begin
                e_an  = 4'hF;
                e_an[digit] = 1'b0;
                e_seg = hex_tbl[(d >> (4 * digit)) & 16'hF];
                e_dp  = (digit == 0) ? ~z : (digit == 1) ? ~n : 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (!reset_n) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            disp_m = '0; zr_m = 1'b0; ng_m = 1'b0; cyc_m = 0;
        end else begin
            exp_out(cyc_m + 1, disp_m, zr_m, ng_m, e_an, e_seg, e_dp);
            if (value_we) begin
                disp_m = value_in; zr_m = zr_in; ng_m = ng_in;
            end
            cyc_m++;
        end
        @(posedge clk);
        #1;
        if (an == 4'hF) blank_cnt++;
        chk("model_an", 32'(an), 32'(e_an));
        chk("model_seg", 32'(seg), 32'(e_seg));
        chk("model_dp", 32'(dp), 32'(e_dp));
        chk("model_shown", 32'(shown_value), 32'(disp_m));
    endtask

    task automatic capture(input logic [15:0] v, input logic z, input logic n);
        value_in = v; zr_in = z; ng_in = n; value_we = 1'b1;
        step();
        value_we = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, input int budget, input string name);
        int i;
        i = 0;
        while (an !== target && i < budget) begin
            step();
            i++;
        end
        chk(name, 32'(an), 32'(target));
    endtask

    initial begin
        hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs[0] = '{16'hA5C3, 1'b0, 1'b0,
                    {7'b0001000, 7'b0010010, 7'b1000110, 7'b0110000}, 4'b1111};
        vecs[1] = '{16'h1234, 1'b1, 1'b0,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1110};
        vecs[2] = '{16'hBEEF, 1'b0, 1'b1,
                    {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}, 4'b1101};
        vecs[3] = '{16'h6789, 1'b1, 1'b1,
                    {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000}, 4'b1100};

        reset_n = 1'b0; value_in = '0; value_we = 1'b0; zr_in = 1'b0; ng_in = 1'b0;
        cyc_m = 0; disp_m = '0; zr_m = 1'b0; ng_m = 1'b0; blank_cnt = 0;

        repeat (5) step();
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_shown", 32'(shown_value), 32'h0);

        reset_n = 1'b1;
        cyc_m = 0;
        step(); chk("release_blank1", 32'(an), 32'hF);
        step(); chk("release_blank2", 32'(an), 32'hF);
        step();
        chk("first_show_an", 32'(an), 32'b1110);
        chk("first_show_seg", 32'(seg), 32'b1000000);

        // Table of captures: each shown across 4 full slots.
        for (int v = 0; v < 4; v++) begin
            capture(vecs[v].value, vecs[v].zr, vecs[v].ng);
            chk("vec_shown", 32'(shown_value), 32'(vecs[v].value));
            step();
            blank_cnt = 0;
            for (int c = 0; c < 4 * SCAN_DIV; c++) begin
                step();
                for (int d = 0; d < 4; d++) begin
                    if (an == ~(4'b0001 << d)) begin
                        chk("vec_seg", 32'(seg), 32'(vecs[v].exp_seg[d]));
                        chk("vec_dp", 32'(dp), 32'(vecs[v].exp_dp[d]));
                    end
                end
            end
            chk("vec_blank_cycles", 32'(blank_cnt), 32'(4 * BLANK_CYCLES));
        end

        // Hold: value_in changes without a strobe.
        value_in = 16'hFFFF; zr_in = 1'b1; ng_in = 1'b1;
        repeat (64) step();
        chk("hold_shown", 32'(shown_value), 32'h6789);

        // Back-to-back strobes: last one wins.
        value_we = 1'b1;
        value_in = 16'h0001; step();
        value_in = 16'h0002; step();
        value_in = 16'h0003; zr_in = 1'b0; ng_in = 1'b0; step();
        value_we = 1'b0;
        chk("b2b_shown", 32'(shown_value), 32'h0003);
        wait_an(4'b1110, 4 * SCAN_DIV + 2, "b2b_wait_digit0");
        chk("b2b_digit0_seg", 32'(seg), 32'b0110000);

        // Random captures against the model.
        for (int i = 0; i < 300; i++) begin
            value_in = 16'($urandom);
            zr_in    = 1'($urandom_range(0, 1));
            ng_in    = 1'($urandom_range(0, 1));
            value_we = ($urandom_range(0, 3) == 0);
            step();
        end
        value_we = 1'b0;

        // Asynchronous reset between edges while a digit is lit.
        wait_an(4'b1011, 4 * SCAN_DIV + 2, "mid_show_wait");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_shown", 32'(shown_value), 32'h0);
        step();
        step();
        reset_n = 1'b1;
        cyc_m = 0;
        step(); chk("restart_blank1", 32'(an), 32'hF);
        step(); chk("restart_blank2", 32'(an), 32'hF);
        step(); chk("restart_digit0", 32'(an), 32'b1110);
        repeat (2 * SCAN_DIV) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
